// File: rtl/cache_way_ctrl.sv
// ---------------------------------------------------------------------------
// cache_way_ctrl
//
// Request-side controller for a 4-way set-associative cache. It takes one CPU
// access at a time and compares the request tag against the four ways of the
// selected set. A hit is answered directly. A miss picks a victim way, writes
// it back to memory if it is dirty, refills it from memory, and then writes
// the new block into the victim way. Saturating hit and miss counters are kept
// for performance reporting. Every output is driven straight from a register.
//
// Ports:
//   clock, resetn          rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready    CPU request handshake
//   req_we/req_tag/req_wdata   access type, tag and write data
//   way_valid/way_dirty/way_tag/way_data   state of the selected set
//   lru0..lru3             per-way LRU age (3 = least recently used)
//   hit                    one-hot hit-way pulse
//   wrenCache              one-hot way write-enable pulse
//   wr_data/wr_tag/set_dirty   contents written along with wrenCache
//   resp_valid/resp_data   response pulse and read data
//   mem_req/mem_we/mem_tag/mem_wdata   memory request (writeback or fill)
//   mem_ready/mem_rdata    memory completion and fill data
//   hit_count/miss_count   saturating statistics counters
// ---------------------------------------------------------------------------
module cache_way_ctrl #(
    parameter int TAG_W  = 8,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [TAG_W-1:0]    req_tag,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [3:0]          way_valid,
    input  logic [3:0]          way_dirty,
    input  logic [4*TAG_W-1:0]  way_tag,
    input  logic [4*DATA_W-1:0] way_data,
    input  logic [1:0]          lru0,
    input  logic [1:0]          lru1,
    input  logic [1:0]          lru2,
    input  logic [1:0]          lru3,
    output logic [3:0]          hit,
    output logic [3:0]          wrenCache,
    output logic [DATA_W-1:0]   wr_data,
    output logic [TAG_W-1:0]    wr_tag,
    output logic                set_dirty,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_data,
    output logic                mem_req,
    output logic                mem_we,
    output logic [TAG_W-1:0]    mem_tag,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [CNT_W-1:0]    hit_count,
    output logic [CNT_W-1:0]    miss_count
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB,
        FILL,
        RESP
    } state_t;

    state_t state, state_nxt;

    // Latched request
    logic              lat_we;
    logic [TAG_W-1:0]  lat_tag;
    logic [DATA_W-1:0] lat_wdata;
    logic [3:0]        victim_oh;

    // Lookup results
    logic [3:0] match;
    logic       any_hit;
    logic [1:0] hit_idx;
    logic [3:0] hit_oh;
    logic [1:0] victim_idx;
    logic [3:0] victim_oh_nxt;
    logic       victim_dirty;
    logic [1:0] lru_age [4];

    // Next values of the registered outputs
    logic              req_ready_n;
    logic [3:0]        hit_n;
    logic [3:0]        wren_n;
    logic [DATA_W-1:0] wr_data_n;
    logic [TAG_W-1:0]  wr_tag_n;
    logic              set_dirty_n;
    logic              resp_valid_n;
    logic [DATA_W-1:0] resp_data_n;
    logic              mem_req_n;
    logic              mem_we_n;
    logic [TAG_W-1:0]  mem_tag_n;
    logic [DATA_W-1:0] mem_wdata_n;
    logic [CNT_W-1:0]  hit_count_n;
    logic [CNT_W-1:0]  miss_count_n;

    // Tag compare and victim choice. Both scan from way 3 down to way 0 so
    // that the last assignment, and therefore the winner, is the lowest index.
    // The victim prefers an invalid way; with a full set it takes the oldest
    // way (age 3), and falls back to way 0 if the ages carry no age-3 entry.
    always_comb begin
        lru_age[0] = lru0;
        lru_age[1] = lru1;
        lru_age[2] = lru2;
        lru_age[3] = lru3;
        match      = '0;
        hit_idx    = 2'd0;
        victim_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            match[i] = way_valid[i] && (way_tag[i*TAG_W +: TAG_W] == lat_tag);
            if (match[i]) begin
                hit_idx = 2'(i);
            end
        end
        if (&way_valid) begin
            for (int i = 3; i >= 0; i--) begin
                if (lru_age[i] == 2'd3) begin
                    victim_idx = 2'(i);
                end
            end
        end else begin
            for (int i = 3; i >= 0; i--) begin
                if (!way_valid[i]) begin
                    victim_idx = 2'(i);
                end
            end
        end
        any_hit       = |match;
        hit_oh        = 4'b0001 << hit_idx;
        victim_oh_nxt = 4'b0001 << victim_idx;
        victim_dirty  = way_valid[victim_idx] && way_dirty[victim_idx];
    end

    // Next-state logic. LOOKUP and RESP always last exactly one cycle; WB and
    // FILL wait for the memory to report completion.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = LOOKUP;
            LOOKUP:  begin
                if (any_hit) begin
                    state_nxt = RESP;
                end else if (victim_dirty) begin
                    state_nxt = WB;
                end else begin
                    state_nxt = FILL;
                end
            end
            WB:      if (mem_ready) state_nxt = FILL;
            FILL:    if (mem_ready) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic. The values computed here are loaded into the output
    // registers on the same edge that moves the state, so each registered
    // output lines up with the state it belongs to. The hit and write-enable
    // pulses default to zero so they only live during the RESP cycle.
    always_comb begin
        req_ready_n  = (state_nxt == IDLE);
        resp_valid_n = (state_nxt == RESP);
        mem_req_n    = (state_nxt == WB) || (state_nxt == FILL);
        mem_we_n     = (state_nxt == WB);
        hit_n        = '0;
        wren_n       = '0;
        wr_data_n    = wr_data;
        wr_tag_n     = wr_tag;
        set_dirty_n  = set_dirty;
        resp_data_n  = resp_data;
        mem_tag_n    = mem_tag;
        mem_wdata_n  = mem_wdata;
        hit_count_n  = hit_count;
        miss_count_n = miss_count;
        case (state)
            LOOKUP: begin
                if (any_hit) begin
                    hit_n = hit_oh;
                    if (hit_count != {CNT_W{1'b1}}) begin
                        hit_count_n = hit_count + 1'b1;
                    end
                    if (lat_we) begin
                        wren_n      = hit_oh;
                        wr_data_n   = lat_wdata;
                        wr_tag_n    = lat_tag;
                        set_dirty_n = 1'b1;
                    end else begin
                        resp_data_n = way_data[int'(hit_idx)*DATA_W +: DATA_W];
                        set_dirty_n = 1'b0;
                    end
                end else begin
                    if (miss_count != {CNT_W{1'b1}}) begin
                        miss_count_n = miss_count + 1'b1;
                    end
                    if (victim_dirty) begin
                        mem_tag_n   = way_tag[int'(victim_idx)*TAG_W +: TAG_W];
                        mem_wdata_n = way_data[int'(victim_idx)*DATA_W +: DATA_W];
                    end else begin
                        mem_tag_n   = lat_tag;
                    end
                end
            end
            WB: begin
                if (mem_ready) begin
                    mem_tag_n = lat_tag;
                end
            end
            FILL: begin
                if (mem_ready) begin
                    resp_data_n = mem_rdata;
                    wren_n      = victim_oh;
                    wr_tag_n    = lat_tag;
                    wr_data_n   = lat_we ? lat_wdata : mem_rdata;
                    set_dirty_n = lat_we;
                end
            end
            default: ;
        endcase
    end

    // State, request latch, victim latch and all output registers. Reset is
    // asynchronous so an access in flight is abandoned at once: mem_req drops
    // without waiting for a clock and no write-enable pulse can follow.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            lat_we     <= 1'b0;
            lat_tag    <= '0;
            lat_wdata  <= '0;
            victim_oh  <= '0;
            req_ready  <= 1'b1;
            hit        <= '0;
            wrenCache  <= '0;
            wr_data    <= '0;
            wr_tag     <= '0;
            set_dirty  <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_tag    <= '0;
            mem_wdata  <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req_valid) begin
                lat_we    <= req_we;
                lat_tag   <= req_tag;
                lat_wdata <= req_wdata;
            end
            if (state == LOOKUP) begin
                victim_oh <= victim_oh_nxt;
            end
            req_ready  <= req_ready_n;
            hit        <= hit_n;
            wrenCache  <= wren_n;
            wr_data    <= wr_data_n;
            wr_tag     <= wr_tag_n;
            set_dirty  <= set_dirty_n;
            resp_valid <= resp_valid_n;
            resp_data  <= resp_data_n;
            mem_req    <= mem_req_n;
            mem_we     <= mem_we_n;
            mem_tag    <= mem_tag_n;
            mem_wdata  <= mem_wdata_n;
            hit_count  <= hit_count_n;
            miss_count <= miss_count_n;
        end
    end

endmodule

// File: tb/tb_cache_way_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cache_way_ctrl
//
// Self-checking bench for cache_way_ctrl. The selected set is held in plain
// arrays; a behavioural model decides hit way, victim, writeback need and the
// counter values from the cache rules, and each access is followed cycle by
// cycle. The counters are made 4 bits wide so saturation is reachable.
// ---------------------------------------------------------------------------
module tb_cache_way_ctrl;

    localparam int TAG_W  = 8;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                clock = 1'b0;
    logic                resetn;
    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [TAG_W-1:0]    req_tag;
    logic [DATA_W-1:0]   req_wdata;
    logic [3:0]          way_valid;
    logic [3:0]          way_dirty;
    logic [4*TAG_W-1:0]  way_tag;
    logic [4*DATA_W-1:0] way_data;
    logic [1:0]          lru0, lru1, lru2, lru3;
    logic [3:0]          hit;
    logic [3:0]          wrenCache;
    logic [DATA_W-1:0]   wr_data;
    logic [TAG_W-1:0]    wr_tag;
    logic                set_dirty;
    logic                resp_valid;
    logic [DATA_W-1:0]   resp_data;
    logic                mem_req;
    logic                mem_we;
    logic [TAG_W-1:0]    mem_tag;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_ready;
    logic [DATA_W-1:0]   mem_rdata;
    logic [CNT_W-1:0]    hit_count;
    logic [CNT_W-1:0]    miss_count;

    // Contents of the selected set as seen by the bench
    logic             vValid [4];
    logic             vDirty [4];
    logic [TAG_W-1:0] vTag   [4];
    logic [DATA_W-1:0] vData [4];
    logic [1:0]       vLru   [4];

    int errors = 0;
    int checks = 0;
    int expHit = 0;
    int expMiss = 0;

    always #5 clock = ~clock;

    assign way_valid = {vValid[3], vValid[2], vValid[1], vValid[0]};
    assign way_dirty = {vDirty[3], vDirty[2], vDirty[1], vDirty[0]};
    assign way_tag   = {vTag[3], vTag[2], vTag[1], vTag[0]};
    assign way_data  = {vData[3], vData[2], vData[1], vData[0]};
    assign lru0 = vLru[0];
    assign lru1 = vLru[1];
    assign lru2 = vLru[2];
    assign lru3 = vLru[3];

    cache_way_ctrl #(.TAG_W(TAG_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_tag(req_tag), .req_wdata(req_wdata),
        .way_valid(way_valid), .way_dirty(way_dirty),
        .way_tag(way_tag), .way_data(way_data),
        .lru0(lru0), .lru1(lru1), .lru2(lru2), .lru3(lru3),
        .hit(hit), .wrenCache(wrenCache), .wr_data(wr_data), .wr_tag(wr_tag),
        .set_dirty(set_dirty), .resp_valid(resp_valid), .resp_data(resp_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_tag(mem_tag),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string name, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic clearSet();
        for (int i = 0; i < 4; i++) begin
            vValid[i] = 1'b0;
            vDirty[i] = 1'b0;
            vTag[i]   = '0;
            vData[i]  = '0;
            vLru[i]   = 2'd0;
        end
    endtask

    task automatic setWay(input int i, input logic v, input logic d,
                          input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] dat,
                          input logic [1:0] age);
        vValid[i] = v;
        vDirty[i] = d;
        vTag[i]   = t;
        vData[i]  = dat;
        vLru[i]   = age;
    endtask

    task automatic checkIdle(input string name);
        checkOutput({name, "_ready"}, 32'(req_ready), 32'd1);
        checkOutput({name, "_resp"}, 32'(resp_valid), 32'd0);
        checkOutput({name, "_hit"}, 32'(hit), 32'd0);
        checkOutput({name, "_wren"}, 32'(wrenCache), 32'd0);
        checkOutput({name, "_memreq"}, 32'(mem_req), 32'd0);
    endtask

    // One full access: model predicts the outcome, then the DUT is followed
    // through every cycle, driving memory completion after the given waits
    task automatic applyStimulus(input logic we, input logic [TAG_W-1:0] tag,
                                 input logic [DATA_W-1:0] wdata,
                                 input int wbWait, input int fillWait,
                                 input logic [DATA_W-1:0] fillData);
        int hitIdx;
        int victim;
        bit needWb;
        logic [TAG_W-1:0] victimTag;
        logic [DATA_W-1:0] victimData;

        hitIdx = -1;
        for (int i = 0; i < 4; i++) begin
            if (hitIdx < 0 && vValid[i] && vTag[i] == tag) hitIdx = i;
        end
        victim = -1;
        for (int i = 0; i < 4; i++) begin
            if (victim < 0 && !vValid[i]) victim = i;
        end
        if (victim < 0) begin
            for (int i = 0; i < 4; i++) begin
                if (victim < 0 && vLru[i] == 2'd3) victim = i;
            end
        end
        if (victim < 0) victim = 0;
        needWb = vValid[victim] && vDirty[victim];
        victimTag = vTag[victim];
        victimData = vData[victim];

        checkOutput("accept_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_tag   = tag;
        req_wdata = wdata;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_we    = ~we;
        req_tag   = ~tag;
        req_wdata = 16'($urandom);
        checkOutput("lookup_ready", 32'(req_ready), 32'd0);
        checkOutput("lookup_resp", 32'(resp_valid), 32'd0);
        @(posedge clock);
        #1;

        if (hitIdx >= 0) begin
            if (expHit < CNT_MAX) expHit++;
            checkOutput("hit_resp", 32'(resp_valid), 32'd1);
            checkOutput("hit_way", 32'(hit), 32'(4'b0001 << hitIdx));
            checkOutput("hit_wren", 32'(wrenCache), we ? 32'(4'b0001 << hitIdx) : 32'd0);
            checkOutput("hit_ready", 32'(req_ready), 32'd0);
            checkOutput("hit_count", 32'(hit_count), 32'(expHit));
            checkOutput("hit_misscnt", 32'(miss_count), 32'(expMiss));
            if (we) begin
                checkOutput("hit_wrdata", 32'(wr_data), 32'(wdata));
                checkOutput("hit_wrtag", 32'(wr_tag), 32'(tag));
                checkOutput("hit_setdirty", 32'(set_dirty), 32'd1);
            end else begin
                checkOutput("hit_rdata", 32'(resp_data), 32'(vData[hitIdx]));
            end
        end else begin
            if (expMiss < CNT_MAX) expMiss++;
            if (needWb) begin
                for (int k = 0; k <= wbWait; k++) begin
                    checkOutput("wb_req", 32'(mem_req), 32'd1);
                    checkOutput("wb_we", 32'(mem_we), 32'd1);
                    checkOutput("wb_tag", 32'(mem_tag), 32'(victimTag));
                    checkOutput("wb_data", 32'(mem_wdata), 32'(victimData));
                    checkOutput("wb_resp", 32'(resp_valid), 32'd0);
                    mem_rdata = 16'($urandom);
                    mem_ready = (k == wbWait);
                    @(posedge clock);
                    #1;
                    mem_ready = 1'b0;
                end
            end
            for (int k = 0; k <= fillWait; k++) begin
                checkOutput("fill_req", 32'(mem_req), 32'd1);
                checkOutput("fill_we", 32'(mem_we), 32'd0);
                checkOutput("fill_tag", 32'(mem_tag), 32'(tag));
                checkOutput("fill_resp", 32'(resp_valid), 32'd0);
                mem_ready = (k == fillWait);
                mem_rdata = (k == fillWait) ? fillData : 16'($urandom);
                @(posedge clock);
                #1;
                mem_ready = 1'b0;
                mem_rdata = 16'($urandom);
            end
            checkOutput("miss_resp", 32'(resp_valid), 32'd1);
            checkOutput("miss_hit", 32'(hit), 32'd0);
            checkOutput("miss_wren", 32'(wrenCache), 32'(4'b0001 << victim));
            checkOutput("miss_wrtag", 32'(wr_tag), 32'(tag));
            checkOutput("miss_wrdata", 32'(wr_data), we ? 32'(wdata) : 32'(fillData));
            checkOutput("miss_setdirty", 32'(set_dirty), 32'(we));
            checkOutput("miss_rdata", 32'(resp_data), 32'(fillData));
            checkOutput("miss_memreq", 32'(mem_req), 32'd0);
            checkOutput("miss_count", 32'(miss_count), 32'(expMiss));
            checkOutput("miss_hitcnt", 32'(hit_count), 32'(expHit));
        end
        @(posedge clock);
        #1;
        checkIdle("after");
    endtask

    // Drops reset in the middle of a fill and checks the access is abandoned
    task automatic resetDuringFill();
        clearSet();
        for (int i = 0; i < 4; i++) setWay(i, 1'b1, 1'b0, 8'h10 + 8'(i), 16'h0, 2'(i));
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_tag   = 8'hC3;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("rst_fill_req", 32'(mem_req), 32'd1);
        #3;
        resetn = 1'b0;
        #1;
        expHit  = 0;
        expMiss = 0;
        checkOutput("rst_memreq", 32'(mem_req), 32'd0);
        checkOutput("rst_wren", 32'(wrenCache), 32'd0);
        checkOutput("rst_hitcnt", 32'(hit_count), 32'd0);
        checkOutput("rst_misscnt", 32'(miss_count), 32'd0);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        mem_ready = 1'b1;
        @(posedge clock);
        #1;
        mem_ready = 1'b0;
        checkIdle("rst_release");
        @(posedge clock);
        #1;
        checkIdle("rst_later");
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetn    = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_tag   = '0;
        req_wdata = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        clearSet();
        #12;
        checkOutput("reset_hit", 32'(hit), 32'd0);
        checkOutput("reset_wren", 32'(wrenCache), 32'd0);
        checkOutput("reset_resp", 32'(resp_valid), 32'd0);
        checkOutput("reset_memreq", 32'(mem_req), 32'd0);
        checkOutput("reset_respdata", 32'(resp_data), 32'd0);
        checkOutput("reset_hitcnt", 32'(hit_count), 32'd0);
        checkOutput("reset_misscnt", 32'(miss_count), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;

        // Read hit on way 2
        clearSet();
        setWay(0, 1'b1, 1'b0, 8'h11, 16'h1111, 2'd0);
        setWay(2, 1'b1, 1'b0, 8'h3A, 16'h1234, 2'd1);
        applyStimulus(1'b0, 8'h3A, 16'h0, 0, 0, 16'h0);

        // Write hit on way 1
        clearSet();
        setWay(1, 1'b1, 1'b0, 8'h05, 16'h5555, 2'd2);
        setWay(3, 1'b1, 1'b1, 8'h05, 16'h6666, 2'd3);
        applyStimulus(1'b1, 8'h05, 16'hBEEF, 0, 0, 16'h0);

        // Clean miss, full set, way 1 is oldest
        clearSet();
        setWay(0, 1'b1, 1'b1, 8'h20, 16'hA0A0, 2'd1);
        setWay(1, 1'b1, 1'b0, 8'h21, 16'hA1A1, 2'd3);
        setWay(2, 1'b1, 1'b1, 8'h22, 16'hA2A2, 2'd0);
        setWay(3, 1'b1, 1'b1, 8'h23, 16'hA3A3, 2'd2);
        applyStimulus(1'b0, 8'h44, 16'h0, 0, 3, 16'h0F0F);

        // Dirty miss, victim way 3 written back through stalls
        clearSet();
        setWay(0, 1'b1, 1'b1, 8'h30, 16'h3030, 2'd0);
        setWay(1, 1'b1, 1'b1, 8'h31, 16'h3131, 2'd1);
        setWay(2, 1'b1, 1'b1, 8'h32, 16'h3232, 2'd2);
        setWay(3, 1'b1, 1'b1, 8'h77, 16'hAAAA, 2'd3);
        applyStimulus(1'b0, 8'h55, 16'h0, 4, 1, 16'h5A5A);

        // Full set with no age-3 way falls back to way 0
        for (int i = 0; i < 4; i++) vLru[i] = 2'd1;
        applyStimulus(1'b0, 8'h66, 16'h0, 1, 0, 16'h6161);

        // Invalid way 0 beats the oldest way; write miss
        clearSet();
        setWay(0, 1'b0, 1'b1, 8'h99, 16'h9999, 2'd0);
        setWay(1, 1'b1, 1'b1, 8'h41, 16'h4141, 2'd3);
        setWay(2, 1'b1, 1'b0, 8'h42, 16'h4242, 2'd1);
        setWay(3, 1'b1, 1'b0, 8'h43, 16'h4343, 2'd2);
        applyStimulus(1'b1, 8'h99, 16'hCAFE, 0, 2, 16'h1357);

        resetDuringFill();

        // Enough hits to drive the hit counter into saturation
        clearSet();
        setWay(0, 1'b1, 1'b0, 8'h01, 16'h0101, 2'd0);
        for (int n = 0; n < CNT_MAX + 3; n++) begin
            applyStimulus(1'b0, 8'h01, 16'h0, 0, 0, 16'h0);
        end

        // Randomized accesses against a small tag space so hits are common
        for (int n = 0; n < 150; n++) begin
            for (int i = 0; i < 4; i++) begin
                setWay(i, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                       8'($urandom_range(0, 7)), 16'($urandom), 2'($urandom_range(0, 3)));
            end
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)),
                          16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                          16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
